// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared types for the AHB slave-port arbiter.
//   htrans_t    : AHB HTRANS encoding
//   hburst_t    : AHB HBURST encoding
//   arb_state_t : arbiter ownership state, with ST_* constants
//   burst_len() : beats in a fixed-length burst, 0 for undefined-length INCR
package ahb_slave_arbiter_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE     = 2'd0;  // no owner
  localparam arb_state_t ST_OWN      = 2'd1;  // fixed-length burst or single
  localparam arb_state_t ST_OWN_INCR = 2'd2;  // undefined-length INCR burst
  localparam arb_state_t ST_LOCKED   = 2'd3;  // owner holds HMASTLOCK

  function automatic logic [4:0] burst_len(input hburst_t burst);
    case (burst)
      HB_SINGLE:           burst_len = 5'd1;
      HB_WRAP4,  HB_INCR4:  burst_len = 5'd4;
      HB_WRAP8,  HB_INCR8:  burst_len = 5'd8;
      HB_WRAP16, HB_INCR16: burst_len = 5'd16;
      default:             burst_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_arbiter_if.sv
// Request/select bundle between the masters of one slave port and its arbiter.
//   hreq      : per-master request (decoder hit and HTRANS NONSEQ/SEQ)
//   htrans    : per-master HTRANS
//   hburst    : per-master HBURST
//   hmastlock : per-master HMASTLOCK
//   hready    : HREADYOUT of the slave
//   sel_addr  : one-hot address-phase select to the payload mux
//   sel_data  : one-hot data-phase select for response routing
//   hold      : per-master stall
// modport master : the bus side that drives requests and the slave's hready
// modport slave  : the arbiter
interface ahb_slave_arbiter_if #(
  parameter int CHANNEL_NUM = 2
);
  logic [CHANNEL_NUM-1:0]       hreq;
  logic [CHANNEL_NUM-1:0][1:0]  htrans;
  logic [CHANNEL_NUM-1:0][2:0]  hburst;
  logic [CHANNEL_NUM-1:0]       hmastlock;
  logic                         hready;
  logic [CHANNEL_NUM-1:0]       sel_addr;
  logic [CHANNEL_NUM-1:0]       sel_data;
  logic [CHANNEL_NUM-1:0]       hold;

  modport master (
    output hreq, htrans, hburst, hmastlock, hready,
    input  sel_addr, sel_data, hold
  );

  modport slave (
    input  hreq, htrans, hburst, hmastlock, hready,
    output sel_addr, sel_data, hold
  );
endinterface

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// Combinational round-robin priority encoder.
//   req   : request vector
//   ptr   : index with highest priority this round
//   idx   : first requester at or after ptr, scanning upward with wrap
//   valid : at least one requester
module ahb_rr_picker #(
  parameter int CHANNEL_NUM = 2,
  parameter int PTR_W       = 1
) (
  input  logic [CHANNEL_NUM-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [PTR_W-1:0]       idx,
  output logic                   valid
);
  logic [CHANNEL_NUM-1:0] rotated;
  int                     pos;

  // Rotate so that bit 0 is the requester at ptr.
  assign rotated = CHANNEL_NUM'({req, req} >> ptr);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    // Scan downward so the lowest offset from ptr is the last one written.
    for (int i = CHANNEL_NUM - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        valid = 1'b1;
        pos   = int'(ptr) + i;
        if (pos >= CHANNEL_NUM) pos = pos - CHANNEL_NUM;
        idx   = PTR_W'(pos);
      end
    end
  end
endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave-port AHB arbiter: round-robin grant with burst and HMASTLOCK hold.
//   HCLK    : clock
//   HRESET  : synchronous active-high reset
//   bus     : ahb_slave_arbiter_if.slave (requests in, sel_addr/sel_data/hold out)
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int CHANNEL_NUM = 2,
  parameter int BEAT_W      = 5
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahb_slave_arbiter_if.slave  bus
);
  localparam int PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  logic [CHANNEL_NUM-1:0] sel_addr_q;
  logic [CHANNEL_NUM-1:0] sel_data_q;
  logic [PTR_W-1:0]       rr_ptr;
  logic [BEAT_W-1:0]      beat_cnt;
  arb_state_t             state;

  logic [PTR_W-1:0]       owner_idx;
  htrans_t                owner_trans;
  logic                   owner_lock;
  logic [4:0]             owner_len;
  logic                   beat_acc;
  logic                   last_beat;
  logic                   arb_point;

  logic [PTR_W-1:0]       win_idx;
  logic                   win_vld;
  logic [CHANNEL_NUM-1:0] win_onehot;
  logic [PTR_W-1:0]       win_next_ptr;

  assign bus.sel_addr = sel_addr_q;
  assign bus.sel_data = sel_data_q;
  assign bus.hold     = bus.hreq & ~sel_addr_q;

  // Owner index from the one-hot select; only meaningful when sel_addr_q != 0.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (sel_addr_q[i]) owner_idx = PTR_W'(i);
    end
  end

  assign owner_trans = htrans_t'(bus.htrans[owner_idx]);
  assign owner_lock  = bus.hmastlock[owner_idx];
  assign owner_len   = burst_len(hburst_t'(bus.hburst[owner_idx]));
  assign beat_acc    = bus.hready &&
                       (owner_trans == HT_NONSEQ || owner_trans == HT_SEQ);
  assign last_beat   = (beat_cnt == BEAT_W'(owner_len - 5'd1));

  always_comb begin
    arb_point = 1'b0;
    if (bus.hready) begin
      case (state)
        ST_IDLE:     arb_point = 1'b1;
        // Final beat of the burst, or the owner abandoned it with IDLE.
        ST_OWN:      arb_point = (beat_acc && last_beat) || (owner_trans == HT_IDLE);
        // A NONSEQ only ends the burst once a beat of it has been accepted;
        // the burst's own opening NONSEQ arrives with beat_cnt still zero.
        ST_OWN_INCR: arb_point = (owner_trans == HT_IDLE) ||
                                 (owner_trans == HT_NONSEQ && beat_cnt != '0);
        ST_LOCKED:   arb_point = !owner_lock &&
                                 (owner_trans == HT_IDLE || owner_trans == HT_NONSEQ);
        default:     arb_point = 1'b1;
      endcase
    end
  end

  ahb_rr_picker #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .PTR_W       (PTR_W)
  ) u_picker (
    .req   (bus.hreq),
    .ptr   (rr_ptr),
    .idx   (win_idx),
    .valid (win_vld)
  );

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign win_next_ptr = (win_idx == PTR_W'(CHANNEL_NUM - 1)) ? '0 : win_idx + 1'b1;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_addr_q <= '0;
      sel_data_q <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      state      <= ST_IDLE;
    end else if (bus.hready) begin
      // With hready low everything holds: a waiting data phase pins the grant.
      sel_data_q <= sel_addr_q;
      if (arb_point) begin
        beat_cnt <= '0;
        if (win_vld) begin
          sel_addr_q <= win_onehot;
          rr_ptr     <= win_next_ptr;
          if (bus.hmastlock[win_idx])
            state <= ST_LOCKED;
          else if (hburst_t'(bus.hburst[win_idx]) == HB_INCR)
            state <= ST_OWN_INCR;
          else
            state <= ST_OWN;
        end else begin
          sel_addr_q <= '0;
          state      <= ST_IDLE;
        end
      end else if (beat_acc && beat_cnt != '1) begin
        // Saturate so a long INCR cannot wrap back to zero.
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  a_sel_addr_onehot0: assert property (@(posedge HCLK) disable iff (HRESET)
    $onehot0(sel_addr_q));
  a_sel_data_onehot0: assert property (@(posedge HCLK) disable iff (HRESET)
    $onehot0(sel_data_q));
  a_sel_addr_frozen: assert property (@(posedge HCLK)
    (!HRESET && !bus.hready) |=> $stable(sel_addr_q));

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter with two masters. Each step drives one
// cycle of inputs and queues the hand-computed outputs for that cycle; a
// separate monitor pops and compares on the falling edge.
module tb_ahb_slave_arbiter;
  import ahb_slave_arbiter_pkg::*;

  localparam htrans_t I = HT_IDLE;
  localparam htrans_t B = HT_BUSY;
  localparam htrans_t N = HT_NONSEQ;
  localparam htrans_t S = HT_SEQ;

  typedef struct {
    int         id;
    logic [1:0] sa;
    logic [1:0] sd;
    logic [1:0] hold;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESET;
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;
  exp_t exp_q[$];

  ahb_slave_arbiter_if #(.CHANNEL_NUM(2)) bus ();

  ahb_slave_arbiter #(
    .CHANNEL_NUM (2),
    .BEAT_W      (5)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input int id,
                       input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, queue outputs expected
  // for this cycle (results of earlier edges; hold follows hreq now).
  task automatic step(input logic rst, input logic [1:0] rq,
                      input htrans_t t0, input htrans_t t1,
                      input hburst_t b0, input hburst_t b1,
                      input logic [1:0] lk, input logic rdy,
                      input logic [1:0] esa, input logic [1:0] esd);
    exp_t e;
    @(posedge HCLK);
    #1;
    HRESET        = rst;
    bus.hreq      = rq;
    bus.htrans[0] = t0;
    bus.htrans[1] = t1;
    bus.hburst[0] = b0;
    bus.hburst[1] = b1;
    bus.hmastlock = lk;
    bus.hready    = rdy;
    step_id++;
    e.id   = step_id;
    e.sa   = esa;
    e.sd   = esd;
    e.hold = rq & ~esa;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sel_addr", e.id, bus.sel_addr, e.sa);
        check("sel_data", e.id, bus.sel_data, e.sd);
        check("hold",     e.id, bus.hold,     e.hold);
      end
    end
  end

  initial begin : stimulus
    HRESET        = 1'b1;
    bus.hreq      = 2'b11;
    bus.htrans[0] = N;
    bus.htrans[1] = N;
    bus.hburst[0] = HB_INCR4;
    bus.hburst[1] = HB_SINGLE;
    bus.hmastlock = 2'b00;
    bus.hready    = 1'b1;

    // Reset held three edges with both masters requesting.
    step(1, 2'b11, N, N, HB_INCR4, HB_SINGLE, 2'b00, 1, 2'b00, 2'b00);
    step(1, 2'b11, N, N, HB_INCR4, HB_SINGLE, 2'b00, 1, 2'b00, 2'b00);
    step(0, 2'b11, N, N, HB_INCR4, HB_SINGLE, 2'b00, 1, 2'b00, 2'b00);
    // Master0 INCR4 (4 beats), master1 waiting.
    step(0, 2'b11, N, N, HB_INCR4, HB_SINGLE, 2'b00, 1, 2'b01, 2'b00);
    step(0, 2'b11, S, N, HB_INCR4, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR4, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR4, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    // SINGLE transfers from both: grant alternates.
    step(0, 2'b11, N, N, HB_SINGLE, HB_SINGLE, 2'b00, 1, 2'b10, 2'b01);
    step(0, 2'b11, N, N, HB_SINGLE, HB_SINGLE, 2'b00, 1, 2'b01, 2'b10);
    step(0, 2'b11, N, N, HB_SINGLE, HB_SINGLE, 2'b00, 1, 2'b10, 2'b01);
    step(0, 2'b11, N, N, HB_SINGLE, HB_SINGLE, 2'b00, 1, 2'b01, 2'b10);
    // Only master1 requests: it wins again.
    step(0, 2'b10, I, N, HB_SINGLE, HB_SINGLE, 2'b00, 1, 2'b10, 2'b01);
    // Master1 INCR8 with a 3-cycle wait at beat 5 and one at beat 8.
    step(0, 2'b11, N, N, HB_SINGLE, HB_INCR8, 2'b00, 1, 2'b10, 2'b10);
    step(0, 2'b11, N, S, HB_SINGLE, HB_INCR8, 2'b00, 1, 2'b10, 2'b10);
    step(0, 2'b11, N, S, HB_SINGLE, HB_INCR8, 2'b00, 1, 2'b10, 2'b10);
    step(0, 2'b11, N, S, HB_SINGLE, HB_INCR8, 2'b00, 1, 2'b10, 2'b10);
    step(0, 2'b11, N, S, HB_SINGLE, HB_INCR8, 2'b00, 0, 2'b10, 2'b10);
    step(0, 2'b11, N, S, HB_SINGLE, HB_INCR8, 2'b00, 0, 2'b10, 2'b10);
    step(0, 2'b11, N, S, HB_SINGLE, HB_INCR8, 2'b00, 0, 2'b10, 2'b10);
    step(0, 2'b11, N, S, HB_SINGLE, HB_INCR8, 2'b00, 1, 2'b10, 2'b10);
    step(0, 2'b11, N, S, HB_SINGLE, HB_INCR8, 2'b00, 1, 2'b10, 2'b10);
    step(0, 2'b11, N, S, HB_SINGLE, HB_INCR8, 2'b00, 1, 2'b10, 2'b10);
    step(0, 2'b11, N, S, HB_SINGLE, HB_INCR8, 2'b00, 0, 2'b10, 2'b10);
    // Beat 8 accepted; master0 (locked) is waiting and wins.
    step(0, 2'b11, N, S, HB_INCR4, HB_INCR8, 2'b01, 1, 2'b10, 2'b10);
    // Master0 locked across two INCR4 bursts.
    step(0, 2'b11, N, N, HB_INCR4, HB_SINGLE, 2'b01, 1, 2'b01, 2'b10);
    step(0, 2'b11, S, N, HB_INCR4, HB_SINGLE, 2'b01, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR4, HB_SINGLE, 2'b01, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR4, HB_SINGLE, 2'b01, 1, 2'b01, 2'b01);
    step(0, 2'b11, N, N, HB_INCR4, HB_SINGLE, 2'b01, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR4, HB_SINGLE, 2'b01, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR4, HB_SINGLE, 2'b01, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR4, HB_SINGLE, 2'b01, 1, 2'b01, 2'b01);
    // Lock dropped with IDLE: master1 granted on the next edge.
    step(0, 2'b10, I, N, HB_INCR4, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    // Master1 SINGLE done; master0 wins with undefined-length INCR.
    step(0, 2'b11, N, N, HB_INCR, HB_SINGLE, 2'b00, 1, 2'b10, 2'b01);
    step(0, 2'b11, N, N, HB_INCR, HB_SINGLE, 2'b00, 1, 2'b01, 2'b10);
    step(0, 2'b11, S, N, HB_INCR, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    step(0, 2'b11, S, N, HB_INCR, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    step(0, 2'b10, B, N, HB_INCR, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    step(0, 2'b10, B, N, HB_INCR, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    step(0, 2'b10, I, N, HB_INCR, HB_SINGLE, 2'b00, 1, 2'b01, 2'b01);
    // Master1 INCR4, reset asserted after its first beat.
    step(0, 2'b11, N, N, HB_SINGLE, HB_INCR4, 2'b00, 1, 2'b10, 2'b01);
    step(1, 2'b11, N, S, HB_SINGLE, HB_INCR4, 2'b00, 1, 2'b10, 2'b10);
    step(0, 2'b11, N, N, HB_SINGLE, HB_INCR4, 2'b00, 1, 2'b00, 2'b00);
    // Everyone goes idle: grant released to no owner.
    step(0, 2'b00, I, I, HB_SINGLE, HB_INCR4, 2'b00, 1, 2'b01, 2'b00);
    step(0, 2'b00, I, I, HB_SINGLE, HB_INCR4, 2'b00, 1, 2'b00, 2'b01);
    step(0, 2'b00, I, I, HB_SINGLE, HB_INCR4, 2'b00, 1, 2'b00, 2'b00);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge HCLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
